mips_mult_unit: RTL and testbench
=================================

Name: mips_mult_unit

Overview:
- Sequential shift-and-add multiplier serving MULT/MULTU in the MIPS datapath.
- Accepts two 32-bit operands via start/busy handshake and produces the 64-bit product in HI/LO after a fixed latency.
- It is the multi-cycle execution-side counterpart to the combinational 32-bit logic blocks (AND/OR/ADD) and their stimulus benches.
- Sits beside the ALU. Control stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH each, the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_signed  in  1  1=MULT (two's complement), 0=MULTU; sampled with start
- a  in  WIDTH  multiplicand; sampled with start
- b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high from the cycle after acceptance until completion
- done  out  1  one-cycle pulse; hi/lo are valid in this cycle
- hi  out  WIDTH  product[2*WIDTH-1:WIDTH]
- lo  out  WIDTH  product[WIDTH-1:0]

Behaviour:
- Reset: state=IDLE; busy, done, hi, lo, counter and internal registers all 0. Reset takes priority at any state, including mid-CALC. An aborted operation leaves hi/lo=0 and produces no done pulse.
- States:
  - IDLE→CALC on start=1. Edge E0 latches mcand=|a|, mplier=|b|, neg=is_signed&(a[31]^b[31]), acc=0, cnt=0.
  - Magnitude is taken only when is_signed=1. |0x80000000| = 0x80000000, treated as unsigned with no overflow.
  - CALC, each edge: if mplier[0]=1, upper accumulator += mcand with a WIDTH+1-bit sum. Then shift {carry, acc, mplier} right by 1; cnt++.
  - CALC→SIGN after 32 iterations (edges E1..E32).
  - SIGN (edge E33): hi:lo ← neg ? -product (64-bit two's complement) : product. done←1, busy←0, state→IDLE.
- busy=1 from E0 through E33 and reads 0 in the cycle after E33. done is high exactly one cycle, the cycle after E33, then returns to 0.
- Latency: start sampled at E0 → done visible 34 cycles later. Throughput: one operation per 34 cycles.
- hi/lo hold their last result until the next SIGN edge. They never show intermediate values.
- Operand changes after E0 have no effect.
- start while busy=1 is ignored; it is neither queued nor reported as an error.
- start in the same cycle as done=1 is accepted, giving back-to-back operation. The new operation's done arrives 34 cycles later.
- Zero operands follow the same 34-cycle latency; there is no early termination.

Decomposition:
- Shared header holds the state encodings (IDLE=2'd0, CALC=2'd1, SIGN=2'd2) and the WIDTH default.
- One natural sub-module: _33bit_adder (WIDTH+1-bit ripple/CLA adder with carry-out), instantiated for the accumulate step.
- The final negate reuses the inverter plus a +1 path inline in the top module.

Test Plan:
- rst held 3 cycles, then released → busy=0, done=0, hi=0, lo=0. No done pulse occurs without start.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000.
- MULT a=7, b=6 started; start pulsed again at cycle 10 with a=1, b=1 → ignored. Result hi=0, lo=42; a single done pulse.
- Back-to-back: start asserted in the done cycle with MULTU a=0x00010000, b=0x00010000 → second done 34 cycles later; hi=0x00000001, lo=0.
- rst asserted at cycle 15 of CALC → next cycle busy=0, hi=lo=0, no done. A new start then completes normally (a=3, b=5 → lo=15).

Source files
------------

// File: rtl/mips_mult_unit_pkg.sv
// Shared types and defaults for the sequential MULT/MULTU unit.
// Holds the FSM state encoding and the default operand and counter widths.
package mips_mult_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

endpackage

// File: rtl/mips_mult_unit_if.sv
// Request/response bundle between pipeline control and the multiplier.
// Control drives the operands; the multiplier returns busy, done and the HI/LO product.
interface mips_mult_unit_if
    import mips_mult_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_mult_unit_33bit_adder.sv
// Accumulate-step adder: two N-bit operands give an (N+1)-bit sum.
// The carry-out becomes the top bit that the shift brings into the accumulator.
module mips_mult_unit_33bit_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y};
endmodule

// File: rtl/mips_mult_unit.sv
// Shift-and-add multiplier for MULT/MULTU: operands in, 64-bit HI/LO out 34 cycles later.
// Works on magnitudes and applies the sign once at the end, so signed and unsigned share one loop.
module mips_mult_unit
    import mips_mult_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input logic             clk,
    input logic             rst,
    mips_mult_unit_if.slave bus
);
    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0]       mcand_reg, mcand_next;
    logic [WIDTH-1:0]       mplier_reg, mplier_next;
    logic [WIDTH-1:0]       acc_reg, acc_next;
    logic                   neg_reg, neg_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic [WIDTH-1:0]       hi_reg, hi_next;
    logic [WIDTH-1:0]       lo_reg, lo_next;

    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [WIDTH-1:0]       addend;
    logic [WIDTH-1:0]       add_sum;
    logic                   add_cout;
    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     product_neg;

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    assign addend = mplier_reg[0] ? mcand_reg : '0;

    mips_mult_unit_33bit_adder #(.N(WIDTH)) u_adder (
        .x    (acc_reg),
        .y    (addend),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign product     = {acc_reg, mplier_reg};
    assign product_neg = ~product + 1'b1;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        neg_next    = neg_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        hi_next     = hi_reg;
        lo_next     = lo_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mcand_next  = a_mag;
                    mplier_next = b_mag;
                    neg_next    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_next    = '0;
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    state_next  = CALC;
                end
            end
            CALC: begin
                // Shift {carry, acc, mplier} right: the consumed multiplier bit drops out
                // and the low accumulator bit moves into the freed top of mplier.
                acc_next    = {add_cout, add_sum[WIDTH-1:1]};
                mplier_next = {add_sum[0], mplier_reg[WIDTH-1:1]};
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = SIGN;
                end
            end
            SIGN: begin
                {hi_next, lo_next} = neg_reg ? product_neg : product;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            neg_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            neg_reg    <= neg_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mips_mult_unit.sv
// Randomized bench for mips_mult_unit: a driver queues expected products, a monitor
// compares each done pulse against them (value and arrival cycle).
module tb_mips_mult_unit;
    localparam int W   = 32;
    localparam int LAT = 34;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
        string        tag;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    int   done_count;
    exp_t sb[$];

    mips_mult_unit_if #(.WIDTH(W)) bus ();

    mips_mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-width product from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 hi=0x%08h lo=0x%08h cycle=%0d",
                         bus.hi, bus.lo, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_product"}, {bus.hi, bus.lo}, {e.hi, e.lo});
                check({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
                check({e.tag, "_busy_low_at_done"}, 64'(bus.busy), 64'd0);
                $display("op %s: hi=0x%08h lo=0x%08h expected hi=0x%08h lo=0x%08h cycle=%0d",
                         e.tag, bus.hi, bus.lo, e.hi, e.lo, cyc);
            end
        end
    end

    // Caller is positioned at a negedge; start is presented for exactly one cycle.
    task automatic start_op(input string tag, input bit s, input logic [W-1:0] x,
                            input logic [W-1:0] y, input bit accept);
        logic [2*W-1:0] p;
        exp_t e;
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.a         = x;
        bus.b         = y;
        if (accept) begin
            p     = ref_mul(s, x, y);
            e.hi  = p[2*W-1:W];
            e.lo  = p[W-1:0];
            e.due = cyc + LAT;
            e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.is_signed = 1'($urandom);
        bus.a         = $urandom;
        bus.b         = $urandom;
        check({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=no_done required=done within %0d cycles", tag, LAT + 10);
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        int dc;
        cyc           = 0;
        checks        = 0;
        failures      = 0;
        done_count    = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        repeat (8) @(negedge clk);
        check("idle_no_done", 64'(done_count), 64'd0);

        start_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("multu_max");
        @(negedge clk);
        start_op("mult_neg2x3", 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        wait_done("mult_neg2x3");
        @(negedge clk);
        start_op("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("mult_minxmin");
        @(negedge clk);

        // Second start while busy must be ignored; the monitor flags any extra done.
        start_op("mult_7x6", 1'b1, 32'd7, 32'd6, 1'b1);
        repeat (8) @(negedge clk);
        start_op("ignored_start", 1'b0, 32'd1, 32'd1, 1'b0);
        wait_done("mult_7x6");

        // Back-to-back: new start presented in the done cycle.
        @(negedge clk);
        start_op("b2b_first", 1'b0, 32'd5, 32'd9, 1'b1);
        wait_done("b2b_first");
        start_op("b2b_second", 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_done("b2b_second");
        check("hold_hi_after_done", 64'(bus.hi), 64'h1);

        // Abort mid-CALC: previous result (non-zero) must be wiped, no done afterwards.
        @(negedge clk);
        start_op("mult_42", 1'b1, 32'd7, 32'd6, 1'b1);
        wait_done("mult_42");
        @(negedge clk);
        start_op("aborted", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        dc = done_count;
        repeat (LAT + 6) @(negedge clk);
        check("abort_no_done", 64'(done_count), 64'(dc));
        start_op("after_abort_3x5", 1'b1, 32'd3, 32'd5, 1'b1);
        wait_done("after_abort_3x5");

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1) == 0) begin
                repeat ($urandom_range(3)) @(negedge clk);
                @(negedge clk);
            end
            start_op($sformatf("rand%0d", i), 1'($urandom), rand_operand(), rand_operand(), 1'b1);
            wait_done($sformatf("rand%0d", i));
        end

        repeat (LAT + 6) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
